// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared definitions for the 7-segment display blocks.
//   state_t   : scan FSM encoding (S_BLANK, S_ON)
//   SEG_BLANK : all segments dark (active-low)
//   AN_OFF    : all anodes disabled (active-low)
package sevenseg_scan_driver_pkg;

  // Two-bit one-hot-style encoding so the unused codes (00, 11) exist and
  // are provably steered back to S_BLANK by the FSM default branch.
  typedef enum logic [1:0] {
    S_BLANK = 2'b01,
    S_ON    = 2'b10
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/sevenseg_scan_driver_hex.sv
// hex_to_sevenseg: purely combinational hex-digit decoder.
//   nibble : 4-bit hex value
//   seg    : {g,f,e,d,c,b,a}, active-low
module hex_to_sevenseg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a value on every
    // path (here via the default branch) so no latch is inferred.
    unique case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment display, with a blanking gap between digits and a frame latch
// so a changing input never tears mid-scan.
//   clk         : system clock
//   reset       : synchronous active-low reset
//   data_in     : four hex nibbles, [15:12] = digit 3 (leftmost)
//   dp_in       : per-digit decimal point request, active-high
//   blank_n     : 0 forces the display dark; scanning continues
//   an          : anode enables, active-low
//   seg         : {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low
//   frame_start : one-cycle pulse on the first lit cycle of digit 3
module sevenseg_scan_driver
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_n,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       digit, digit_d;
  logic [15:0]      frame_data, frame_data_d;
  logic [3:0]       frame_dp, frame_dp_d;

  logic [3:0] an_d;
  logic [6:0] seg_d, seg_dec;
  logic       dp_d, frame_start_d, lit;

  // Next-state logic. In S_BLANK, digit already names the digit about to
  // light, so the latch fires on the blank that precedes digit 3.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt + 1'b1;
    digit_d      = digit;
    frame_data_d = frame_data;
    frame_dp_d   = frame_dp;
    unique case (state)
      S_BLANK: begin
        // >= keeps the counter bounded even if it were ever corrupted.
        if (cnt >= BLANK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
          if (digit == 2'd3) begin
            frame_data_d = data_in;
            frame_dp_d   = dp_in;
          end
        end
      end
      S_ON: begin
        if (cnt >= DWELL_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          digit_d = digit - 2'd1;  // 0 wraps to 3
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
        digit_d = 2'd3;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered outputs
  // line up cycle-for-cycle with the registered state.
  hex_to_sevenseg u_dec (
    .nibble (frame_data_d[4*digit_d +: 4]),
    .seg    (seg_dec)
  );

  always_comb begin
    lit           = (state_d == S_ON) && blank_n;
    an_d          = lit ? ~(4'b0001 << digit_d) : AN_OFF;
    seg_d         = lit ? seg_dec : SEG_BLANK;
    dp_d          = lit ? ~frame_dp_d[digit_d] : 1'b1;
    frame_start_d = (state_d == S_ON) && (cnt_d == '0) && (digit_d == 2'd3);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state       <= S_BLANK;
      cnt         <= '0;
      digit       <= 2'd3;
      // NOTE: the frame latch is reset too; it is a handful of flops, not
      // a memory, and the first frame must not show X.
      frame_data  <= 16'h0000;
      frame_dp    <= 4'b0000;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      digit       <= digit_d;
      frame_data  <= frame_data_d;
      frame_dp    <= frame_dp_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver (DWELL_CYCLES=4, BLANK_CYCLES=2).
// The model tracks the position within the 24-cycle frame and derives the
// display from it; a compare process checks every cycle at negedge, and
// directed literal checks pin the model at chosen points.
module tb_sevenseg_scan_driver;

  localparam int DWELL  = 4;
  localparam int BLANK  = 2;
  localparam int SLOT   = DWELL + BLANK;
  localparam int PERIOD = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        blank_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_n     (blank_n),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // ---------------- model ----------------
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit          m_valid = 0;
  int          m_p = 0;        // position in frame; 0..1 blank before digit 3
  logic [15:0] m_fd;
  logic [3:0]  m_fdp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fs;

  always @(posedge clk) begin
    if (!reset) begin
      m_valid = 1;
      m_p     = 0;
      m_fd    = 16'h0000;
      m_fdp   = 4'h0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    end else if (m_valid) begin
      int dig;
      bit on;
      if (m_p == BLANK - 1) begin
        m_fd  = data_in;
        m_fdp = dp_in;
      end
      m_p  = (m_p + 1) % PERIOD;
      dig  = 3 - m_p / SLOT;
      on   = (m_p % SLOT) >= BLANK;
      e_fs = (m_p == BLANK);
      if (on && blank_n) begin
        e_an  = 4'hF & ~(4'(1) << dig);
        e_seg = dec_tab[(m_fd >> (4 * dig)) & 16'hF];
        e_dp  = ~m_fdp[dig];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_an", 16'(an), 16'(e_an));
      check("cyc_seg", 16'(seg), 16'(e_seg));
      check("cyc_dp", 16'(dp), 16'(e_dp));
      check("cyc_fs", 16'(frame_start), 16'(e_fs));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    step();
    while (m_p != target && n < 64) begin
      step();
      n++;
    end
    if (m_p != target) begin
      checks++;
      $display("FAIL wait_pos: position %0d expected %0d", m_p, target);
    end
  endtask

  int fs_cnt;

  initial begin
    reset = 1'b0; data_in = 16'h1234; dp_in = 4'h0; blank_n = 1'b1;

    // 1: held in reset
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_an", 16'(an), 16'hF);
      check("rst_seg", 16'(seg), 16'h7F);
      check("rst_fs", 16'(frame_start), 16'h0);
    end

    // 2: release, two dark cycles then digit 3
    reset = 1'b1;
    step();
    check("rel_dark_an", 16'(an), 16'hF);
    step();
    check("d3_an", 16'(an), 16'h7);
    check("d3_seg", 16'(seg), 16'h79);
    check("d3_fs", 16'(frame_start), 16'h1);
    step();
    check("d3_fs_once", 16'(frame_start), 16'h0);

    // 3: change data during digit 3 dwell (position 3)
    data_in = 16'hABCD;
    wait_pos(8);  check("old_d2", 16'(seg), 16'h24); check("old_d2_an", 16'(an), 16'hB);
    wait_pos(14); check("old_d1", 16'(seg), 16'h30); check("old_d1_an", 16'(an), 16'hD);
    wait_pos(20); check("old_d0", 16'(seg), 16'h19); check("old_d0_an", 16'(an), 16'hE);
    wait_pos(2);  check("new_d3", 16'(seg), 16'h08);
    wait_pos(8);  check("new_d2", 16'(seg), 16'h03);
    wait_pos(14); check("new_d1", 16'(seg), 16'h46);
    wait_pos(20); check("new_d0", 16'(seg), 16'h21);

    // 4: one-cycle reset during digit 1 dwell
    data_in = 16'h5678;
    wait_pos(14);
    reset = 1'b0;
    step();
    check("midrst_an", 16'(an), 16'hF);
    check("midrst_seg", 16'(seg), 16'h7F);
    reset = 1'b1;
    step();
    check("midrst_gap", 16'(an), 16'hF);
    step();
    check("midrst_d3_an", 16'(an), 16'h7);
    check("midrst_d3_seg", 16'(seg), 16'h12);

    // 5: blank_n low for 30 cycles starting at position 3
    step();
    blank_n = 1'b0;
    fs_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (frame_start) fs_cnt++;
      check("blank_an", 16'(an), 16'hF);
    end
    check("blank_fs_count", 16'(fs_cnt), 16'd1);
    blank_n = 1'b1;
    step();
    check("unblank_an", 16'(an), 16'hB);
    check("unblank_seg", 16'(seg), 16'h02);

    // 6: decimal point on digit 2 only
    dp_in = 4'b0100;
    wait_pos(2);  check("dp_d3", 16'(dp), 16'h1);
    wait_pos(6);  check("dp_gap", 16'(dp), 16'h1);
    wait_pos(8);  check("dp_d2", 16'(dp), 16'h0); check("dp_d2_an", 16'(an), 16'hB);
    wait_pos(14); check("dp_d1", 16'(dp), 16'h1);

    @(posedge clk);
    m_valid = 0;
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
